// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller with alignment/range checks and one-cycle memory access
module lsu_mem_ctrl #(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_sign,
  input  logic [1:0]           req_width,
  input  logic [REG_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_WIDTH-1:0] resp_rdata,
  output logic [4:0]           resp_rd,
  output logic                 resp_misal,
  output logic                 resp_range,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemSign,
  output logic [1:0]           MemWidth,
  output logic [REG_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic [REG_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic we_q, sign_q, misal_q, range_q;
  logic [1:0] width_q;
  logic [4:0] rd_q;
  logic [REG_WIDTH-1:0] addr_q, wdata_q, rdata_q, size_m1;
  logic [ADDR_WIDTH:0] end_addr;
  logic misal, out_range, accept;
  // fault classification of the incoming request; the last byte must also stay in range
  always_comb begin
    size_m1   = (REG_WIDTH'(1) << req_width) - REG_WIDTH'(1);
    misal     = |(req_addr & size_m1);
    end_addr  = {1'b0, req_addr[ADDR_WIDTH-1:0]} + size_m1[ADDR_WIDTH:0];
    out_range = (|req_addr[REG_WIDTH-1:ADDR_WIDTH]) | end_addr[ADDR_WIDTH];
    accept    = (state == IDLE) & req_valid & ~flush;
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  // next state: flush aborts everything, faults skip the memory access
  always_comb
    state_nxt = flush ? IDLE :
                state == IDLE   ? (req_valid ? ((misal | out_range) ? RESP : ACCESS) : IDLE) :
                state == ACCESS ? RESP :
                (resp_ready ? IDLE : RESP);
  // handshake and memory strobes; strobes are suppressed by flush or reset in the access cycle
  always_comb begin
    req_ready  = (state == IDLE) & ~flush;
    resp_valid = state == RESP;
    MemRead    = (state == ACCESS) & ~we_q & ~flush & rst_n;
    MemWrite   = (state == ACCESS) & we_q & ~flush & rst_n;
  end
  // request latch and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      misal_q <= 1'b0;
      range_q <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      sign_q  <= req_sign;
      width_q <= req_width;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rd_q    <= req_rd;
      rdata_q <= '0;
      misal_q <= misal;
      range_q <= ~misal & out_range;
    end else if (state == ACCESS && !flush) begin
      rdata_q <= we_q ? '0 : mem_rdata;
    end
  end
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_misal = misal_q;
  assign resp_range = range_q;
  assign MemSign    = sign_q;
  assign MemWidth   = width_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench with a byte-array reference model and a behavioural data memory
module tb_lsu_mem_ctrl;
  logic clk = 0, rst_n = 0, flush = 0, req_valid = 0, req_we = 0, req_sign = 0, resp_ready = 0;
  logic [1:0] req_width = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [4:0] req_rd = 0;
  logic req_ready, resp_valid, resp_misal, resp_range, MemRead, MemWrite, MemSign;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [4:0] resp_rd;
  logic [1:0] MemWidth;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        misal;
    logic        rng;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, acc_exp = 0, acc_seen = 0;
  logic hold = 0, mem_init = 0;
  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];

  lsu_mem_ctrl #(.REG_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_sign(req_sign), .req_width(req_width), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_misal(resp_misal), .resp_range(resp_range),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSign(MemSign), .MemWidth(MemWidth),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // width/sign extension from the data-memory contract: sign=0 sign-extends, sign=1 zero-extends
  function automatic logic [63:0] ext(input logic [63:0] v, input logic [1:0] w, input logic sg);
    int n;
    logic [63:0] m;
    n = 8 << w;
    if (n == 64) return v;
    m = (64'd1 << n) - 64'd1;
    return (sg || !v[n-1]) ? (v & m) : (v | ~m);
  endfunction

  function automatic logic [63:0] ref_get(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i+:8] = ref_mem[a[9:0] + 10'(i)];
    return v;
  endfunction

  // behavioural data memory: combinational extended read, write at the clock edge
  always_comb begin
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i+:8] = mem[mem_addr[9:0] + 10'(i)];
    mem_rdata = MemRead ? ext(v, MemWidth, MemSign) : 64'd0;
  end
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << MemWidth)) mem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i+:8];
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // consumer backpressure: random unless a test holds it low
  initial forever begin
    @(posedge clk);
    #1 resp_ready = !hold && ($urandom_range(0, 3) != 0);
  end

  // monitor: pops the scoreboard on every response handshake, counts memory strobes
  initial forever begin
    @(negedge clk);
    if (MemRead || MemWrite) begin
      acc_seen++;
      chk("mem_strobe_excl", {63'd0, MemRead & MemWrite}, 64'd0);
    end
    if (resp_valid && resp_ready && rst_n) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got rd=%0d with empty scoreboard", resp_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_rd", 64'(resp_rd), 64'(e.rd));
        chk("resp_rdata", resp_rdata, e.data);
        chk("resp_misal", 64'(resp_misal), 64'(e.misal));
        chk("resp_range", 64'(resp_range), 64'(e.rng));
      end
    end
  end

  // present a request, wait for acceptance, then push the model's expected response
  task automatic issue(input logic we, input logic sg, input logic [1:0] w, input logic [63:0] a,
                       input logic [63:0] d, input logic [4:0] rd);
    bit ok;
    exp_t e;
    int sz;
    ok = 0;
    req_we = we; req_sign = sg; req_width = w; req_addr = a; req_wdata = d; req_rd = rd;
    req_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
    end else begin
      sz = 1 << w;
      e.rd = rd;
      e.data = 64'd0;
      e.misal = (a % 64'(sz)) != 0;
      e.rng = !e.misal && (a >= 64'd1024 || a + 64'(sz) > 64'd1024);
      if (!e.misal && !e.rng) begin
        acc_exp++;
        if (we) for (int i = 0; i < sz; i++) ref_mem[a[9:0] + 10'(i)] = d[8*i+:8];
        else e.data = ext(ref_get(a), w, sg);
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_resp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got resp_valid=0 expected 1 within 20 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_ld;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    mem_init = 1;
    repeat (3) @(posedge clk);
    #1 mem_init = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_memread", 64'(MemRead), 64'd0);
    chk("rst_memwrite", 64'(MemWrite), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(posedge clk);
    #1;
    // directed word/byte traffic and boundaries
    issue(1, 0, 2, 64'h10, 64'hDEADBEEF, 1);
    issue(0, 0, 2, 64'h10, 64'h0, 2);
    issue(0, 1, 2, 64'h10, 64'h0, 3);
    issue(1, 0, 0, 64'h3, 64'h80, 4);
    issue(0, 0, 0, 64'h3, 64'h0, 5);
    issue(0, 0, 1, 64'h3, 64'h0, 6);
    issue(0, 0, 2, 64'h3FC, 64'h0, 7);
    issue(0, 0, 3, 64'h3F8, 64'h0, 8);
    issue(0, 0, 3, 64'h400, 64'h0, 9);
    issue(0, 0, 3, 64'h3FC, 64'h0, 10);
    issue(0, 1, 3, 64'h1_0000_0000, 64'h0, 11);
    drain();
    chk("lw_sext_value", ext(ref_get(64'h10), 2, 0), 64'hFFFFFFFFDEADBEEF);
    chk("lb_sext_value", ext(ref_get(64'h3), 0, 0), 64'hFFFFFFFFFFFFFF80);
    // backpressure: response held stable, a waiting request is not accepted
    hold = 1;
    exp_ld = ext(ref_get(64'h10), 2, 1);
    issue(0, 1, 2, 64'h10, 64'h0, 12);
    wait_resp();
    req_we = 0; req_sign = 0; req_width = 3; req_addr = 64'h8; req_rd = 13; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'd1);
      chk("hold_resp_rdata", resp_rdata, exp_ld);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    hold = 0;
    issue(0, 0, 3, 64'h8, 64'h0, 13);
    drain();
    // flush during the access cycle of a store leaves memory untouched
    issue(1, 0, 3, 64'h20, {$urandom, $urandom}, 14);
    drain();
    @(posedge clk);
    #1;
    req_we = 1; req_sign = 0; req_width = 3; req_addr = 64'h20; req_wdata = 64'h1122334455667788;
    req_rd = 15; req_valid = 1;
    @(negedge clk);
    chk("flush_pre_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 0;
    flush = 1;
    @(negedge clk);
    chk("flush_memwrite", 64'(MemWrite), 64'd0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("flush_resp_valid", 64'(resp_valid), 64'd0);
    chk("flush_idle_ready", 64'(req_ready), 64'd1);
    flush = 1;
    req_valid = 1;
    #1 chk("flush_blocks_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 0;
    req_valid = 0;
    @(negedge clk);
    chk("flush_no_accept", 64'(resp_valid | MemRead | MemWrite), 64'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 3, 64'h20, 64'h0, 16);
    drain();
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [1:0] w;
      logic [63:0] a;
      int r;
      w = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      a = 64'($urandom_range(0, 1023));
      if (r < 6) a = a & ~((64'd1 << w) - 64'd1);
      else if (r == 8) a = {$urandom, $urandom};
      else if (r == 9) a = 64'd1024 - 64'(8 << w) + 64'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, a, {$urandom, $urandom},
            5'($urandom_range(0, 31)));
    end
    drain();
    // reset while a response is pending
    hold = 1;
    issue(0, 0, 3, 64'h18, 64'h0, 17);
    wait_resp();
    rst_n = 0;
    @(negedge clk);
    chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    chk("rstmid_resp_rdata", resp_rdata, 64'd0);
    chk("rstmid_resp_rd", 64'(resp_rd), 64'd0);
    chk("rstmid_flags", 64'({resp_misal, resp_range}), 64'd0);
    chk("rstmid_strobes", 64'({MemRead, MemWrite}), 64'd0);
    chk("rstmid_mem_addr", mem_addr, 64'd0);
    chk("rstmid_mem_wdata", mem_wdata, 64'd0);
    void'(q.pop_back());
    rst_n = 1;
    hold = 0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_resp", 64'(resp_valid), 64'd0);
    chk("mem_access_count", 64'(acc_seen), 64'(acc_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
